// File: rtl/seq_normalizer.sv
// rtl/seq_normalizer.sv - sequential left-shift normalizer (unsigned / signed), one operand in flight
// Optional two-bit-per-cycle stepping when NORM_FAST_EN is defined.
module seq_normalizer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_shift,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_U = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] MAX_S = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_signed;
  logic             r_zero;
  logic             r_valid;
  logic             r_ready;

  logic [CNT_W-1:0] w_max;
  logic             w_is_zero;
  logic             w_norm;
  logic             w_at_max;
  logic             w_fast;

  assign w_max     = r_signed ? MAX_S : MAX_U;
  assign w_is_zero = (r_reg == '0);
  assign w_norm    = r_signed ? (r_reg[WIDTH-1] ^ r_reg[WIDTH-2]) : r_reg[WIDTH-1];
  assign w_at_max  = (r_cnt == w_max);

`ifdef NORM_FAST_EN
  localparam logic [CNT_W:0] TWO = (CNT_W+1)'(2);
  logic [CNT_W:0] w_cnt_p2;
  logic           w_two_free;

  // Two redundant top bits guarantee a double shift cannot skip past normalization.
  assign w_cnt_p2   = {1'b0, r_cnt} + TWO;
  assign w_two_free = r_signed
                    ? ((r_reg[WIDTH-1] == r_reg[WIDTH-2]) && (r_reg[WIDTH-2] == r_reg[WIDTH-3]))
                    : (r_reg[WIDTH-1:WIDTH-2] == 2'b00);
  assign w_fast     = !w_is_zero && (w_cnt_p2 <= {1'b0, w_max}) && w_two_free;
`else
  assign w_fast = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_reg    <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_ready) begin
            r_reg    <= in_data;
            r_cnt    <= '0;
            r_signed <= in_signed;
            r_zero   <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_is_zero) begin
            r_cnt   <= w_max;
            r_zero  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else if (w_norm || w_at_max) begin
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else if (w_fast) begin
            r_reg <= {r_reg[WIDTH-3:0], 2'b00};
            r_cnt <= r_cnt + CNT_W'(2);
          end else begin
            r_reg <= {r_reg[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_ready;
  assign out_valid = r_valid;
  assign out_data  = r_reg;
  assign out_shift = r_cnt;
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_seq_normalizer.sv
// tb/tb_seq_normalizer.sv - table, corner-case and random checks of seq_normalizer against a reference model
module tb_seq_normalizer;

`ifdef NORM_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_signed = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [3:0] out_shift;
  logic       out_zero;

  int total = 0;
  int bad   = 0;

  seq_normalizer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_signed(in_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_shift(out_shift),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sgn;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] sh;
    logic       zr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Expected result from the definition: shift until the top bit (or top two bits differ), capped at MAX.
  function automatic void model(input logic sgn, input logic [7:0] d,
                                output logic [7:0] od, output int n, output logic z);
    int mx;
    logic [7:0] v;
    mx = sgn ? 7 : 8;
    v  = d;
    z  = (d == 8'h00);
    n  = 0;
    if (z) begin
      od = 8'h00;
      n  = mx;
    end else begin
      while (n < mx && !(sgn ? (v[7] != v[6]) : (v[7] == 1'b1))) begin
        v = v << 1;
        n++;
      end
      od = v;
    end
  endfunction

  function automatic int exp_latency(input int n, input logic z);
    if (z) return 1;
    if (FAST) return (n + 1) / 2 + 1;
    return n + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic sgn, input logic [7:0] d, input string nm);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      step();
      w++;
    end
    check({nm, "_ready_before"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_signed = sgn;
    in_data   = d;
    step();
    in_valid  = 1'b0;
    in_signed = 1'($urandom);
    in_data   = 8'($urandom);
    check({nm, "_ready_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic do_op(input logic sgn, input logic [7:0] d, input logic [7:0] ed,
                       input logic [3:0] es, input logic ez, input string nm);
    int lat;
    accept(sgn, d, nm);
    wait_valid(lat);
    check({nm, "_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_lat"}, 32'(lat), 32'(exp_latency(int'(es), ez)));
    check({nm, "_data"}, 32'(out_data), 32'(ed));
    check({nm, "_shift"}, 32'(out_shift), 32'(es));
    check({nm, "_zero"}, 32'(out_zero), 32'(ez));
    step();
    check({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h10, 8'h80, 4'd3, 1'b0};
    vecs[1]  = '{1'b1, 8'hF2, 8'h90, 4'd3, 1'b0};
    vecs[2]  = '{1'b1, 8'hFF, 8'h80, 4'd7, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 4'd8, 1'b1};
    vecs[4]  = '{1'b1, 8'h00, 8'h00, 4'd7, 1'b1};
    vecs[5]  = '{1'b0, 8'h81, 8'h81, 4'd0, 1'b0};
    vecs[6]  = '{1'b1, 8'h40, 8'h40, 4'd0, 1'b0};
    vecs[7]  = '{1'b0, 8'h01, 8'h80, 4'd7, 1'b0};
    vecs[8]  = '{1'b1, 8'h01, 8'h40, 4'd6, 1'b0};
    vecs[9]  = '{1'b1, 8'hC0, 8'h80, 4'd1, 1'b0};
    vecs[10] = '{1'b0, 8'h3C, 8'hF0, 4'd2, 1'b0};
    vecs[11] = '{1'b1, 8'h1F, 8'h7C, 4'd2, 1'b0};
    vecs[12] = '{1'b1, 8'h80, 8'h80, 4'd0, 1'b0};
    vecs[13] = '{1'b1, 8'hE0, 8'h80, 4'd2, 1'b0};

    step();
    step();
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_shift", 32'(out_shift), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd0);
    rst = 1'b0;
    step();

    foreach (vecs[i])
      do_op(vecs[i].sgn, vecs[i].din, vecs[i].dout, vecs[i].sh, vecs[i].zr, $sformatf("vec%0d", i));

    // Unsigned 0x01 must finish within 5 edges in the fast build.
    if (FAST) begin
      int lat;
      accept(1'b0, 8'h01, "fast01");
      wait_valid(lat);
      check("fast01_within5", 32'(lat <= 5), 32'd1);
      step();
    end

    // Backpressure: result held, in_ready low, stray in_valid ignored.
    begin
      int lat;
      out_ready = 1'b0;
      accept(1'b0, 8'h10, "bp");
      wait_valid(lat);
      check("bp_valid", 32'(out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_signed = 1'b1;
        step();
        check($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
        check($sformatf("bp_hold_data%0d", k), 32'(out_data), 32'h80);
        check($sformatf("bp_hold_shift%0d", k), 32'(out_shift), 32'd3);
        check($sformatf("bp_hold_zero%0d", k), 32'(out_zero), 32'd0);
        check($sformatf("bp_hold_ready%0d", k), 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_ready", 32'(in_ready), 32'd1);
      do_op(1'b0, 8'h81, 8'h81, 4'd0, 1'b0, "bp_b2b");
    end

    // Reset mid-SHIFT discards the operand.
    accept(1'b0, 8'h01, "rs");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_data", 32'(out_data), 32'd0);
    check("rs_shift", 32'(out_shift), 32'd0);
    check("rs_zero", 32'(out_zero), 32'd0);
    check("rs_ready", 32'(in_ready), 32'd1);

    // Reset mid-DONE.
    begin
      int lat;
      out_ready = 1'b0;
      accept(1'b0, 8'h00, "rd");
      wait_valid(lat);
      check("rd_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      check("rd_valid_clr", 32'(out_valid), 32'd0);
      check("rd_shift_clr", 32'(out_shift), 32'd0);
      check("rd_zero_clr", 32'(out_zero), 32'd0);
      check("rd_ready", 32'(in_ready), 32'd1);
    end

    for (int r = 0; r < 200; r++) begin
      logic       sgn;
      logic [7:0] d;
      logic [7:0] od;
      int         n;
      logic       z;
      sgn = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       d = 8'($urandom) >> $urandom_range(0, 7);
        1:       d = ~(8'($urandom) >> $urandom_range(0, 7));
        default: d = 8'($urandom);
      endcase
      model(sgn, d, od, n, z);
      do_op(sgn, d, od, 4'(n), z, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
